// File: rtl/spi_master_shifter.sv
`default_nettype none
// ============================================================================
//  Module   : spi_master_shifter
//  Purpose  : SPI mode-0 master shifter. One transfer of DATA_WIDTH bits,
//             MSB first, with a lead-in and trail-out half period around the
//             SCLK burst. All outputs come straight from flops.
//  Ports    : clk      - system clock, rising edge
//             rst      - asynchronous active-high reset
//             start    - transfer request, honoured only when idle
//             tx_data  - word to send, captured when start is accepted
//             miso     - serial data from slave
//             sclk     - SPI clock (idle low)
//             mosi     - serial data to slave
//             cs_n     - active-low slave select
//             rx_data  - last fully received word
//             busy     - transfer in progress
//             done     - one-cycle completion pulse
//  Revision : 1.0 - initial release
// ============================================================================
module spi_master_shifter #(
  parameter int DATA_WIDTH = 8,
  parameter int CLK_DIV    = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [DATA_WIDTH-1:0] tx_data,
  input  logic                  miso,
  output logic                  sclk,
  output logic                  mosi,
  output logic                  cs_n,
  output logic [DATA_WIDTH-1:0] rx_data,
  output logic                  busy,
  output logic                  done
);

  localparam int CNT_W = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  localparam int BIT_W = $clog2(DATA_WIDTH + 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LEAD  = 2'd1,
    S_SHIFT = 2'd2,
    S_TRAIL = 2'd3
  } state_t;

  state_t                state_q,   state_d;
  logic [CNT_W-1:0]      cnt_q,     cnt_d;
  logic [BIT_W-1:0]      bit_cnt_q, bit_cnt_d;
  // The MSB is presented on mosi directly at load, so only the remaining
  // DATA_WIDTH-1 bits need to be kept for later shifting.
  logic [DATA_WIDTH-2:0] tx_sr_q,   tx_sr_d;
  logic [DATA_WIDTH-1:0] rx_sr_q,   rx_sr_d;
  logic [DATA_WIDTH-1:0] rx_data_q, rx_data_d;
  logic                  sclk_q,    sclk_d;
  logic                  mosi_q,    mosi_d;
  logic                  cs_n_q,    cs_n_d;
  logic                  busy_q,    busy_d;
  logic                  done_q,    done_d;
  logic                  tick;

  assign tick = (cnt_q == CNT_W'(CLK_DIV - 1));

  always_comb begin
    state_d   = state_q;
    // Free-running half-period counter; it wraps on tick, and every state
    // change happens on tick, so each state is entered with the count at 0.
    cnt_d     = tick ? '0 : cnt_q + CNT_W'(1);
    bit_cnt_d = bit_cnt_q;
    tx_sr_d   = tx_sr_q;
    rx_sr_d   = rx_sr_q;
    rx_data_d = rx_data_q;
    sclk_d    = sclk_q;
    mosi_d    = mosi_q;
    cs_n_d    = cs_n_q;
    busy_d    = busy_q;
    done_d    = 1'b0;

    case (state_q)
      S_IDLE: begin
        cnt_d  = '0;
        cs_n_d = 1'b1;
        sclk_d = 1'b0;
        mosi_d = 1'b0;
        busy_d = 1'b0;
        if (start) begin
          state_d   = S_LEAD;
          tx_sr_d   = tx_data[DATA_WIDTH-2:0];
          rx_sr_d   = '0;
          bit_cnt_d = '0;
          mosi_d    = tx_data[DATA_WIDTH-1];
          cs_n_d    = 1'b0;
          busy_d    = 1'b1;
        end
      end

      S_LEAD: begin
        if (tick) begin
          state_d = S_SHIFT;
        end
      end

      S_SHIFT: begin
        if (tick) begin
          if (!sclk_q) begin
            // Rising edge: slave data has been stable since the last fall.
            sclk_d    = 1'b1;
            rx_sr_d   = {rx_sr_q[DATA_WIDTH-2:0], miso};
            bit_cnt_d = bit_cnt_q + BIT_W'(1);
          end else begin
            sclk_d  = 1'b0;
            mosi_d  = tx_sr_q[DATA_WIDTH-2];
            tx_sr_d = tx_sr_q << 1;
            if (bit_cnt_q == BIT_W'(DATA_WIDTH)) begin
              state_d = S_TRAIL;
            end
          end
        end
      end

      S_TRAIL: begin
        if (tick) begin
          state_d   = S_IDLE;
          cs_n_d    = 1'b1;
          busy_d    = 1'b0;
          mosi_d    = 1'b0;
          done_d    = 1'b1;
          rx_data_d = rx_sr_q;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      bit_cnt_q <= '0;
      tx_sr_q   <= '0;
      rx_sr_q   <= '0;
      rx_data_q <= '0;
      sclk_q    <= 1'b0;
      mosi_q    <= 1'b0;
      cs_n_q    <= 1'b1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_cnt_q <= bit_cnt_d;
      tx_sr_q   <= tx_sr_d;
      rx_sr_q   <= rx_sr_d;
      rx_data_q <= rx_data_d;
      sclk_q    <= sclk_d;
      mosi_q    <= mosi_d;
      cs_n_q    <= cs_n_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign sclk    = sclk_q;
  assign mosi    = mosi_q;
  assign cs_n    = cs_n_q;
  assign rx_data = rx_data_q;
  assign busy    = busy_q;
  assign done    = done_q;

endmodule
`default_nettype wire

// File: tb/tb_spi_master_shifter.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : tb_spi_master_shifter
//  Purpose  : Self-checking bench for spi_master_shifter. Instance A uses the
//             default parameters, instance B uses CLK_DIV=2, DATA_WIDTH=16.
//             Expected receive words are queued at start and popped at done.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_spi_master_shifter;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  // ---------------- instance A: defaults ----------------
  logic       start_a = 1'b0;
  logic [7:0] tx_a    = 8'h00;
  logic       miso_a;
  logic       sclk_a, mosi_a, cs_n_a, busy_a, done_a;
  logic [7:0] rx_a;

  // Slave model: loopback, or a fixed pattern shifted out on sclk falls.
  logic       loop_a = 1'b1;
  logic [7:0] sl_pat = 8'h00;
  int         sl_idx = 7;
  always @(negedge sclk_a or posedge cs_n_a) begin
    if (cs_n_a)          sl_idx = 7;
    else if (sl_idx > 0) sl_idx = sl_idx - 1;
  end
  assign miso_a = loop_a ? mosi_a : sl_pat[sl_idx[2:0]];

  spi_master_shifter u_dut_a (
    .clk(clk), .rst(rst), .start(start_a), .tx_data(tx_a), .miso(miso_a),
    .sclk(sclk_a), .mosi(mosi_a), .cs_n(cs_n_a), .rx_data(rx_a),
    .busy(busy_a), .done(done_a)
  );

  // ---------------- instance B: CLK_DIV=2, DATA_WIDTH=16 ----------------
  logic        start_b = 1'b0;
  logic [15:0] tx_b    = 16'h0000;
  logic        miso_b;
  logic        sclk_b, mosi_b, cs_n_b, busy_b, done_b;
  logic [15:0] rx_b;
  assign miso_b = mosi_b;

  spi_master_shifter #(.DATA_WIDTH(16), .CLK_DIV(2)) u_dut_b (
    .clk(clk), .rst(rst), .start(start_b), .tx_data(tx_b), .miso(miso_b),
    .sclk(sclk_b), .mosi(mosi_b), .cs_n(cs_n_b), .rx_data(rx_b),
    .busy(busy_b), .done(done_b)
  );

  // ---------------- checking ----------------
  int         n_vec = 0;
  int         n_err = 0;
  logic [7:0] exp_q[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic pop_chk(input string tag);
    logic [7:0] e;
    if (exp_q.size() == 0) begin
      chk({tag, "_sb_empty"}, 32'd1, 32'd0);
    end else begin
      e = exp_q.pop_front();
      chk({tag, "_rx"}, {24'd0, rx_a}, {24'd0, e});
    end
  endtask

  // One transfer on A. tx_a is replaced by mid after the 3rd sclk pulse.
  task automatic xfer_a(input logic [7:0] tx, input logic [7:0] mid,
                        input logic [7:0] exp_rx, input string tag);
    int         low, pulses, run, guard, hmin, hmax, lmin, lmax;
    logic       prev;
    logic [7:0] cap, held;
    exp_q.push_back(exp_rx);
    tx_a = tx; start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    low = 0; pulses = 0; run = 0; guard = 0; prev = 1'b0; cap = 8'h00;
    hmin = 999; hmax = 0; lmin = 999; lmax = 0;
    while (!done_a && guard < 2000) begin
      if (!cs_n_a) low++;
      if (sclk_a != prev) begin
        if (prev) begin
          if (run < hmin) hmin = run;
          if (run > hmax) hmax = run;
        end else if (pulses > 0) begin
          if (run < lmin) lmin = run;
          if (run > lmax) lmax = run;
        end
        if (sclk_a) begin
          pulses++;
          cap = {cap[6:0], mosi_a};
          if (pulses == 3) tx_a = mid;
        end
        run = 1;
      end else begin
        run++;
      end
      prev = sclk_a; guard++;
      @(negedge clk);
    end
    chk({tag, "_done_seen"}, {31'd0, done_a}, 32'd1);
    chk({tag, "_cs_low_cycles"}, low, 72);
    chk({tag, "_pulses"}, pulses, 8);
    chk({tag, "_mosi_seq"}, {24'd0, cap}, {24'd0, tx});
    chk({tag, "_sclk_hi_min"}, hmin, 4);
    chk({tag, "_sclk_hi_max"}, hmax, 4);
    chk({tag, "_sclk_lo_min"}, lmin, 4);
    chk({tag, "_sclk_lo_max"}, lmax, 4);
    chk({tag, "_cs_at_done"}, {31'd0, cs_n_a}, 32'd1);
    chk({tag, "_busy_at_done"}, {31'd0, busy_a}, 32'd0);
    pop_chk(tag);
    held = rx_a;
    repeat (3) @(negedge clk);
    chk({tag, "_rx_hold"}, {24'd0, rx_a}, {24'd0, held});
    chk({tag, "_mosi_idle"}, {31'd0, mosi_a}, 32'd0);
  endtask

  initial begin
    #1 rst = 1'b1;
    #1;
    chk("rst_cs_n",  {31'd0, cs_n_a}, 32'd1);
    chk("rst_sclk",  {31'd0, sclk_a}, 32'd0);
    chk("rst_mosi",  {31'd0, mosi_a}, 32'd0);
    chk("rst_busy",  {31'd0, busy_a}, 32'd0);
    chk("rst_done",  {31'd0, done_a}, 32'd0);
    chk("rst_rx",    {24'd0, rx_a},   32'd0);
    chk("rst_b_cs_n",{31'd0, cs_n_b}, 32'd1);
    chk("rst_b_rx",  {16'd0, rx_b},   32'd0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Loopback A5, then slave pattern C3, then tx changed mid-transfer.
    loop_a = 1'b1;
    xfer_a(8'hA5, 8'hA5, 8'hA5, "loop_a5");
    loop_a = 1'b0; sl_pat = 8'hC3;
    xfer_a(8'h3C, 8'h3C, 8'hC3, "slave_c3");
    loop_a = 1'b1;
    xfer_a(8'h00, 8'hFF, 8'h00, "tx_change");

    // start held high across three transfers.
    begin
      int   ndone, hi_run, guard;
      logic was_low;
      tx_a = 8'h5A;
      repeat (3) exp_q.push_back(8'h5A);
      start_a = 1'b1;
      @(negedge clk);
      ndone = 0; hi_run = 0; guard = 0; was_low = 1'b0;
      while (ndone < 3 && guard < 1000) begin
        if (done_a) begin
          ndone++;
          pop_chk("b2b");
          if (ndone == 3) start_a = 1'b0;
        end
        if (cs_n_a) begin
          hi_run++;
        end else begin
          if (was_low && hi_run > 0) chk("b2b_gap", hi_run, 1);
          hi_run = 0;
          was_low = 1'b1;
        end
        guard++;
        if (ndone < 3) @(negedge clk);
      end
      chk("b2b_done_count", ndone, 3);
      repeat (10) @(negedge clk);
      chk("b2b_idle_cs", {31'd0, cs_n_a}, 32'd1);
      chk("b2b_idle_busy", {31'd0, busy_a}, 32'd0);
    end

    // Asynchronous reset at the 3rd sclk rise.
    begin
      int   rises, guard, ndone;
      logic prev;
      tx_a = 8'h96; start_a = 1'b1;
      @(negedge clk);
      start_a = 1'b0;
      rises = 0; guard = 0; prev = 1'b0;
      while (rises < 3 && guard < 500) begin
        if (sclk_a && !prev) rises++;
        prev = sclk_a; guard++;
        if (rises < 3) @(negedge clk);
      end
      chk("arst_reached_rise3", rises, 3);
      #2 rst = 1'b1;
      #1;
      chk("arst_cs_n", {31'd0, cs_n_a}, 32'd1);
      chk("arst_sclk", {31'd0, sclk_a}, 32'd0);
      chk("arst_busy", {31'd0, busy_a}, 32'd0);
      chk("arst_mosi", {31'd0, mosi_a}, 32'd0);
      chk("arst_rx",   {24'd0, rx_a},   32'd0);
      #1 rst = 1'b0;
      ndone = 0;
      repeat (60) begin
        @(negedge clk);
        if (done_a) ndone++;
      end
      chk("arst_no_done", ndone, 0);
      chk("arst_rx_after", {24'd0, rx_a}, 32'd0);
    end
    xfer_a(8'h69, 8'h69, 8'h69, "post_rst");

    // Instance B: CLK_DIV=2, DATA_WIDTH=16.
    begin
      int          low, pulses, guard;
      logic        prev;
      logic [15:0] cap;
      tx_b = 16'h8001; start_b = 1'b1;
      @(negedge clk);
      start_b = 1'b0;
      low = 0; pulses = 0; guard = 0; prev = 1'b0; cap = 16'h0000;
      while (!done_b && guard < 2000) begin
        if (!cs_n_b) low++;
        if (sclk_b && !prev) begin
          pulses++;
          cap = {cap[14:0], mosi_b};
        end
        prev = sclk_b; guard++;
        @(negedge clk);
      end
      chk("b16_done_seen", {31'd0, done_b}, 32'd1);
      chk("b16_cs_low_cycles", low, 68);
      chk("b16_pulses", pulses, 16);
      chk("b16_mosi_seq", {16'd0, cap}, 32'h0000_8001);
      chk("b16_rx", {16'd0, rx_b}, 32'h0000_8001);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
